// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch sequencer sitting after the PC register.
// It reads pc and returns next_pc. Each PC gets one instruction-memory read
// over a valid/ready request and response-valid channel. The fetched word is
// held in a one-entry buffer that decode drains with a valid/ready handshake.
// A branch or jump redirect flushes the buffer and discards any fetch still
// in flight.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   pc / next_pc                    PC register read value / load value (comb)
//   redirect_valid, redirect_pc     branch/jump redirect and its target
//   imem_req_valid/ready/addr       instruction-memory request channel
//   imem_resp_valid/data            instruction-memory response
//   inst_valid/ready, inst_pc/data  buffered instruction handed to decode
module fetch_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PC_STEP = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_data
);

    // REQ: free to issue; WAIT: one request outstanding; DRAIN: outstanding request is stale
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] issued_addr;
    logic            req_fire;
    logic            fill;

    assign imem_req_addr = pc;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next state, request issue and next_pc; a redirect overrides everything else
    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        req_fire       = 1'b0;
        fill           = 1'b0;
        next_pc        = pc;
        if (redirect_valid) begin
            next_pc = redirect_pc & ~XLEN'(3);
            case (state)
                WAIT, DRAIN: state_next = imem_resp_valid ? REQ : DRAIN;
                default:     state_next = REQ;
            endcase
        end else begin
            case (state)
                REQ: begin
                    // Issue only when the buffer is empty or drains on this edge
                    imem_req_valid = !inst_valid || inst_ready;
                    req_fire       = imem_req_valid && imem_req_ready;
                    if (req_fire) begin
                        next_pc    = pc + XLEN'(PC_STEP);
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        fill       = 1'b1;
                        state_next = REQ;
                    end
                end
                DRAIN: begin
                    // Stale response is dropped on arrival
                    if (imem_resp_valid) begin
                        state_next = REQ;
                    end
                end
                default: state_next = REQ;
            endcase
        end
    end

    // Issued address and instruction buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            issued_addr <= '0;
            inst_valid  <= 1'b0;
            inst_pc     <= '0;
            inst_data   <= '0;
        end else begin
            if (req_fire) begin
                issued_addr <= pc;
            end
            if (redirect_valid) begin
                inst_valid <= 1'b0;
            end else if (fill) begin
                inst_valid <= 1'b1;
                inst_pc    <= issued_addr;
                inst_data  <= imem_resp_data;
            end else if (inst_valid && inst_ready) begin
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven bench for fetch_unit. Each table row is
// one clock cycle: inputs are driven after the falling edge, and the outputs
// are compared 1 time unit later (combinational outputs for this cycle,
// registered outputs from the previous rising edge).
module tb_fetch_unit;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] inst_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .PC_STEP(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .next_pc         (next_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_pc         (inst_pc),
        .inst_data       (inst_data)
    );

    typedef struct {
        logic        chk;
        logic        rst;
        logic [31:0] pc;
        logic        rv;
        logic [31:0] rpc;
        logic        rqr;
        logic        rsv;
        logic [31:0] rsd;
        logic        ir;
        logic        e_rqv;
        logic [31:0] e_npc;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic [31:0] e_id;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic chk, input logic rst, input logic [31:0] p,
                       input logic rv, input logic [31:0] rpc, input logic rqr,
                       input logic rsv, input logic [31:0] rsd, input logic ir,
                       input logic e_rqv, input logic [31:0] e_npc, input logic e_iv,
                       input logic [31:0] e_ipc, input logic [31:0] e_id);
        vec_t v;
        v.chk = chk; v.rst = rst; v.pc = p; v.rv = rv; v.rpc = rpc; v.rqr = rqr;
        v.rsv = rsv; v.rsd = rsd; v.ir = ir; v.e_rqv = e_rqv; v.e_npc = e_npc;
        v.e_iv = e_iv; v.e_ipc = e_ipc; v.e_id = e_id;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [31:0] p, input logic rv,
                         input logic [31:0] rpc, input logic rqr, input logic rsv,
                         input logic [31:0] rsd, input logic ir);
        reset = rst; pc = p; redirect_valid = rv; redirect_pc = rpc;
        imem_req_ready = rqr; imem_resp_valid = rsv; imem_resp_data = rsd; inst_ready = ir;
    endtask

    localparam logic [31:0] P  = 32'h0040_0000;
    localparam logic [31:0] D  = 32'h2008_0005;
    localparam logic [31:0] D2 = 32'h0000_0013;
    localparam logic [31:0] D3 = 32'h2222_2222;

    initial begin
        logic [31:0] cur;
        drive(1'b1, P, 0, 0, 0, 0, 0, 0);

        // chk rst pc rv rpc rqr rsv rsd ir | rqv npc iv ipc id
        // Basic fetch, 1-cycle response
        add(0, 1, P,      0, 0, 0, 0, 0, 0,   0, 0,      0, 0, 0);
        add(1, 0, P,      0, 0, 1, 0, 0, 0,   1, P+4,    0, 0, 0);
        add(1, 0, P+4,    0, 0, 1, 1, D, 0,   0, P+4,    0, 0, 0);
        // Decode stalls 4 cycles with a full buffer
        for (int i = 0; i < 4; i++)
            add(1, 0, P+4, 0, 0, 1, 0, 0, 0,  0, P+4,    1, P, D);
        // Decode accepts; next request issues the same cycle
        add(1, 0, P+4,    0, 0, 1, 0, 0, 1,   1, P+8,    1, P, D);
        add(1, 0, P+8,    0, 0, 1, 1, D2, 1,  0, P+8,    0, P, D);
        // Memory not ready for 5 cycles
        add(1, 0, P+8,    0, 0, 0, 0, 0, 1,   1, P+8,    1, P+4, D2);
        for (int i = 0; i < 4; i++)
            add(1, 0, P+8, 0, 0, 0, 0, 0, 1,  1, P+8,    0, P+4, D2);
        add(1, 0, P+8,    0, 0, 1, 0, 0, 1,   1, P+12,   0, P+4, D2);
        // Redirect in WAIT, response two cycles later is dropped
        add(1, 0, P+12,   1, 32'h0040_0103, 1, 0, 0, 1,   0, 32'h0040_0100, 0, P+4, D2);
        add(1, 0, 32'h0040_0100, 0, 0, 1, 0, 0, 1,        0, 32'h0040_0100, 0, P+4, D2);
        add(1, 0, 32'h0040_0100, 0, 0, 1, 1, 32'hDEAD_BEEF, 1, 0, 32'h0040_0100, 0, P+4, D2);
        add(1, 0, 32'h0040_0100, 0, 0, 1, 0, 0, 1,        1, 32'h0040_0104, 0, P+4, D2);
        // Redirect coincides with response in WAIT
        add(1, 0, 32'h0040_0104, 1, 32'h0040_0200, 1, 1, 32'h1111_1111, 1, 0, 32'h0040_0200, 0, P+4, D2);
        add(1, 0, 32'h0040_0200, 0, 0, 0, 0, 0, 0,        1, 32'h0040_0200, 0, P+4, D2);
        add(1, 0, 32'h0040_0200, 0, 0, 1, 0, 0, 0,        1, 32'h0040_0204, 0, P+4, D2);
        add(1, 0, 32'h0040_0204, 0, 0, 1, 1, D3, 0,       0, 32'h0040_0204, 0, P+4, D2);
        // Redirect in REQ flushes a full buffer
        add(1, 0, 32'h0040_0204, 1, 32'h0040_0302, 1, 0, 0, 0, 0, 32'h0040_0300, 1, 32'h0040_0200, D3);
        add(1, 0, 32'h0040_0300, 0, 0, 0, 0, 0, 0,        1, 32'h0040_0300, 0, 32'h0040_0200, D3);
        // PC wrap, then reset while in WAIT; late response ignored in REQ
        add(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0);
        add(1, 0, 32'hFFFF_FFFC, 0, 0, 1, 0, 0, 0,        1, 32'h0000_0000, 0, 0, 0);
        add(0, 1, 32'h0000_0000, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0);
        add(1, 0, 32'h0000_0000, 0, 0, 0, 1, 32'h3333_3333, 0, 1, 0, 0, 0, 0);
        add(1, 0, 32'h0000_0000, 0, 0, 0, 0, 0, 0,        1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].pc, vecs[i].rv, vecs[i].rpc, vecs[i].rqr,
                  vecs[i].rsv, vecs[i].rsd, vecs[i].ir);
            #1;
            if (vecs[i].chk) begin
                check($sformatf("row%0d req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_rqv));
                check($sformatf("row%0d req_addr", i), imem_req_addr, vecs[i].pc);
                check($sformatf("row%0d next_pc", i), next_pc, vecs[i].e_npc);
                check($sformatf("row%0d inst_valid", i), 32'(inst_valid), 32'(vecs[i].e_iv));
                check($sformatf("row%0d inst_pc", i), inst_pc, vecs[i].e_ipc);
                check($sformatf("row%0d inst_data", i), inst_data, vecs[i].e_id);
            end
        end

        // Streaming at peak rate: one instruction every two cycles
        @(negedge clk);
        drive(1'b1, 32'h0000_1000, 0, 0, 0, 0, 0, 0);
        cur = 32'h0000_1000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b0, cur, 0, 0, 1, 0, 0, 1);
            #1;
            check($sformatf("stream%0d req_valid", k), 32'(imem_req_valid), 32'd1);
            check($sformatf("stream%0d next_pc", k), next_pc, cur + 32'd4);
            if (k > 0) begin
                check($sformatf("stream%0d inst_valid", k), 32'(inst_valid), 32'd1);
                check($sformatf("stream%0d inst_pc", k), inst_pc, cur - 32'd4);
                check($sformatf("stream%0d inst_data", k), inst_data, 32'hA000 + 32'(k - 1));
            end
            @(negedge clk);
            drive(1'b0, cur + 32'd4, 0, 0, 1, 1, 32'hA000 + 32'(k), 1);
            #1;
            check($sformatf("stream%0d wait req_valid", k), 32'(imem_req_valid), 32'd0);
            cur = cur + 32'd4;
        end
        @(negedge clk);
        drive(1'b0, cur, 0, 0, 0, 0, 0, 1);
        #1;
        check("stream tail inst_valid", 32'(inst_valid), 32'd1);
        check("stream tail inst_pc", inst_pc, cur - 32'd4);
        check("stream tail inst_data", inst_data, 32'h0000_A003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
